riscv_core_div_out: RTL and testbench

//  Post-processing stage of the M-extension divider. Captures per-op sign/special-case

---
 rtl/riscv_core_div_pkg.sv | 26 ++
 rtl/riscv_core_div_meta_fifo.sv | 61 ++++++
 rtl/riscv_core_div_out.sv | 123 ++++++++++++
 tb/tb_riscv_core_div_out.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_div_pkg.sv
// Shared types and helpers for the M-extension divider post-processing stage.
// The design is built for the XLEN fixed here; the top's XLEN parameter must match it.
package riscv_core_div_pkg;

  localparam int DIV_XLEN = 64;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct packed {
    logic [1:0]          op;
    logic                isword;
    logic                neg_q;
    logic                neg_r;
    logic                divz;
    logic                ovf;
    logic [DIV_XLEN-1:0] dvd;
  } div_meta_t;

  function automatic logic [DIV_XLEN-1:0] sext_word(input logic [DIV_XLEN-1:0] v);
    return {{(DIV_XLEN/2){v[DIV_XLEN/2-1]}}, v[DIV_XLEN/2-1:0]};
  endfunction

endpackage

// File: rtl/riscv_core_div_meta_fifo.sv
// Small in-order queue of per-op divider metadata; push, pop and flush.
// Pushes that arrive while the queue is full and pops that arrive while it is empty are ignored.
module riscv_core_div_meta_fifo
  import riscv_core_div_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            flush,
  input  logic            push,
  input  div_meta_t       push_data,
  input  logic            pop,
  output div_meta_t       head,
  output logic            empty,
  output logic [CW-1:0]   count
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  div_meta_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_core_div_out.sv
// Divider result post-processing: records sign/special-case flags at issue, then
// fixes up the unsigned core result and registers it toward writeback.
module riscv_core_div_out
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_div_out_flush,
  input  logic            i_div_out_issue_valid,
  output logic            o_div_out_issue_ready,
  input  logic [1:0]      i_div_out_control,
  input  logic            i_div_out_isword,
  input  logic [XLEN-1:0] i_div_out_srcA,
  input  logic [XLEN-1:0] i_div_out_srcB,
  input  logic            i_div_out_res_valid,
  output logic            o_div_out_res_ready,
  input  logic [XLEN-1:0] i_div_out_quotient,
  input  logic [XLEN-1:0] i_div_out_remainder,
  output logic            o_div_out_valid,
  input  logic            i_div_out_ready,
  output logic [XLEN-1:0] o_div_out_result,
  output logic            o_div_out_busy
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(DEPTH + 1);

  localparam logic [XLEN-1:0] DWORD_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [HALF-1:0] WORD_MIN  = {1'b1, {(HALF-1){1'b0}}};
  localparam logic [XLEN-1:0] WORD_MIN_SEXT = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  div_meta_t     meta_in;
  div_meta_t     head;
  logic          empty;
  logic [CW-1:0] count;
  logic          issue_fire;
  logic          res_fire;
  logic          signed_op;
  logic          sign_a;
  logic          sign_b;
  logic [XLEN-1:0] final_res;

  assign o_div_out_issue_ready = (count < CW'(DEPTH));
  assign o_div_out_res_ready   = ~empty & (~o_div_out_valid | i_div_out_ready);
  assign o_div_out_busy        = ~empty | o_div_out_valid;
  assign issue_fire            = i_div_out_issue_valid & o_div_out_issue_ready;
  assign res_fire              = i_div_out_res_valid & o_div_out_res_ready;

  // DIV and REM are the signed encodings (control bit 0 clear).
  assign signed_op = ~i_div_out_control[0];
  assign sign_a    = signed_op & (i_div_out_isword ? i_div_out_srcA[HALF-1] : i_div_out_srcA[XLEN-1]);
  assign sign_b    = signed_op & (i_div_out_isword ? i_div_out_srcB[HALF-1] : i_div_out_srcB[XLEN-1]);

  always_comb begin
    meta_in        = '0;
    meta_in.op     = i_div_out_control;
    meta_in.isword = i_div_out_isword;
    meta_in.neg_q  = sign_a ^ sign_b;
    meta_in.neg_r  = sign_a;
    if (i_div_out_isword) begin
      meta_in.divz = (i_div_out_srcB[HALF-1:0] == '0);
      meta_in.ovf  = signed_op & (i_div_out_srcA[HALF-1:0] == WORD_MIN)
                               & (i_div_out_srcB[HALF-1:0] == '1);
      meta_in.dvd  = sext_word(i_div_out_srcA);
    end else begin
      meta_in.divz = (i_div_out_srcB == '0);
      meta_in.ovf  = signed_op & (i_div_out_srcA == DWORD_MIN) & (i_div_out_srcB == '1);
      meta_in.dvd  = i_div_out_srcA;
    end
  end

  riscv_core_div_meta_fifo #(.DEPTH(DEPTH)) u_meta_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .flush     (i_div_out_flush),
    .push      (issue_fire),
    .push_data (meta_in),
    .pop       (res_fire),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

  logic            is_rem;
  logic            negate;
  logic [XLEN-1:0] mag;
  logic [XLEN-1:0] sel;

  assign is_rem = head.op[1];

  // Special cases take precedence; core data is meaningless for them.
  always_comb begin
    mag    = is_rem ? i_div_out_remainder : i_div_out_quotient;
    negate = is_rem ? head.neg_r : head.neg_q;
    sel    = negate ? (~mag + XLEN'(1)) : mag;
    if (head.divz) begin
      sel = is_rem ? head.dvd : '1;
    end else if (head.ovf) begin
      if (is_rem)           sel = '0;
      else if (head.isword) sel = WORD_MIN_SEXT;
      else                  sel = DWORD_MIN;
    end
    final_res = head.isword ? sext_word(sel) : sel;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_div_out_valid  <= 1'b0;
      o_div_out_result <= '0;
    end else if (i_div_out_flush) begin
      o_div_out_valid  <= 1'b0;
    end else if (res_fire) begin
      o_div_out_valid  <= 1'b1;
      o_div_out_result <= final_res;
    end else if (i_div_out_ready) begin
      o_div_out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_core_div_out.sv
// Directed bench for riscv_core_div_out: hand-computed results for signed/unsigned,
// word, div-by-zero, overflow, backpressure, flush and async reset.
module tb_riscv_core_div_out;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  control;
  logic        isword;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riscv_core_div_out #(.XLEN(64), .DEPTH(2)) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_div_out_flush       (flush),
    .i_div_out_issue_valid (issue_valid),
    .o_div_out_issue_ready (issue_ready),
    .i_div_out_control     (control),
    .i_div_out_isword      (isword),
    .i_div_out_srcA        (src_a),
    .i_div_out_srcB        (src_b),
    .i_div_out_res_valid   (res_valid),
    .o_div_out_res_ready   (res_ready),
    .i_div_out_quotient    (quotient),
    .i_div_out_remainder   (remainder),
    .o_div_out_valid       (out_valid),
    .i_div_out_ready       (out_ready),
    .o_div_out_result      (result),
    .o_div_out_busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Drives one issue for a single cycle (call at a negedge, returns at the next negedge).
  task automatic do_issue(input logic [1:0] c, input logic w, input logic [63:0] a, input logic [63:0] b);
    issue_valid = 1'b1;
    control     = c;
    isword      = w;
    src_a       = a;
    src_b       = b;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  // Single op end to end with writeback always ready.
  task automatic run_op(input string tag, input logic [1:0] c, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] q, input logic [63:0] r, input logic [63:0] exp);
    @(negedge clk);
    check({tag, ".issue_ready"}, 64'(issue_ready), 64'd1);
    do_issue(c, w, a, b);
    res_valid = 1'b1;
    quotient  = q;
    remainder = r;
    check({tag, ".res_ready"}, 64'(res_ready), 64'd1);
    check({tag, ".valid_early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    res_valid = 1'b0;
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".result"}, result, exp);
    @(negedge clk);
    check({tag, ".drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; control = 2'b00; isword = 1'b0;
    src_a = '0; src_b = '0; res_valid = 1'b0; quotient = '0; remainder = '0; out_ready = 1'b1;
    #23;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.result", result, 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.issue_ready", 64'(issue_ready), 64'd1);
    check("rst.res_ready", 64'(res_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("div_neg", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_neg", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd3, 64'd1, ONES);
    run_op("divu_z", 2'b01, 1'b0, 64'd5, 64'd0, 64'hDEAD, 64'hDEAD, ONES);
    run_op("rem_z", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hDEAD, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'hDEAD, 64'hDEAD, 64'h8000_0000_0000_0000);
    run_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'hDEAD, 64'hDEAD, 64'd0);
    run_op("divw_ovf", 2'b00, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'hDEAD, 64'hDEAD, 64'hFFFF_FFFF_8000_0000);
    run_op("divuw", 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFE, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("remu", 2'b11, 1'b0, 64'd7, 64'd3, 64'd2, 64'd1, 64'd1);
    run_op("divw_neg", 2'b00, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("remw_z", 2'b10, 1'b1, 64'h0000_0001_8000_0005, 64'h0000_0001_0000_0000, 64'hDEAD, 64'hDEAD,
           64'hFFFF_FFFF_8000_0005);

    // Backpressure: one result held in the output, two more ops queued.
    @(negedge clk);
    out_ready = 1'b0;
    do_issue(2'b01, 1'b0, 64'd10, 64'd3);
    res_valid = 1'b1; quotient = 64'd3; remainder = 64'd1;
    @(negedge clk);
    res_valid = 1'b0;
    check("bp.first_valid", 64'(out_valid), 64'd1);
    do_issue(2'b11, 1'b0, 64'd10, 64'd3);
    do_issue(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF6, 64'd3);
    res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp.issue_ready", 64'(issue_ready), 64'd0);
      check("bp.res_ready", 64'(res_ready), 64'd0);
      check("bp.hold_result", result, 64'd3);
      check("bp.hold_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.second_valid", 64'(out_valid), 64'd1);
    check("bp.second", result, 64'd1);
    @(negedge clk);
    res_valid = 1'b0;
    check("bp.third_valid", 64'(out_valid), 64'd1);
    check("bp.third", result, 64'hFFFF_FFFF_FFFF_FFFD);
    @(negedge clk);
    check("bp.idle_valid", 64'(out_valid), 64'd0);
    check("bp.idle_busy", 64'(busy), 64'd0);

    // Flush with a valid output and a full queue; a same-cycle result handshake is dropped.
    out_ready = 1'b0;
    do_issue(2'b01, 1'b0, 64'd10, 64'd3);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    do_issue(2'b01, 1'b0, 64'd20, 64'd3);
    do_issue(2'b01, 1'b0, 64'd30, 64'd3);
    check("fl.pre_valid", 64'(out_valid), 64'd1);
    check("fl.pre_issue_ready", 64'(issue_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1; res_valid = 1'b1; quotient = 64'd6;
    @(negedge clk);
    flush = 1'b0; res_valid = 1'b0;
    check("fl.valid", 64'(out_valid), 64'd0);
    check("fl.busy", 64'(busy), 64'd0);
    check("fl.issue_ready", 64'(issue_ready), 64'd1);
    check("fl.res_ready", 64'(res_ready), 64'd0);

    // Async reset while an output is pending.
    out_ready = 1'b0;
    do_issue(2'b01, 1'b0, 64'd9, 64'd3);
    res_valid = 1'b1; quotient = 64'd3;
    @(negedge clk);
    res_valid = 1'b0;
    do_issue(2'b01, 1'b0, 64'd9, 64'd3);
    check("ar.pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar.valid", 64'(out_valid), 64'd0);
    check("ar.result", result, 64'd0);
    check("ar.busy", 64'(busy), 64'd0);
    check("ar.issue_ready", 64'(issue_ready), 64'd1);
    check("ar.res_ready", 64'(res_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("ar.post_valid", 64'(out_valid), 64'd0);
    check("ar.post_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
